// File: rtl/ysyx_23060077_riscv_axil_sram_pkg.sv
// Shared definitions for the AXI-Lite data SRAM: response codes, channel FSM
// states and the delay LFSR polynomial.
package ysyx_23060077_riscv_axil_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // x^8 + x^6 + x^5 + x^4 + 1 as a right-shifting Galois toggle mask
  localparam int         LFSR_WIDTH = 8;
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // One Galois step: shift right, fold the dropped bit back through the taps.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    return {1'b0, s[LFSR_WIDTH-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // True when addr falls inside [base, base + 4*2^depth_log2).
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int          depth_log2);
    logic [32:0] span;
    logic [32:0] off;
    span = 33'd4 << depth_log2;
    off  = {1'b0, addr - base};
    return (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/ysyx_23060077_riscv_axil_sram_lfsr8.sv
// Free-running 8-bit Galois LFSR; one instance supplies both channel delays.
module ysyx_23060077_riscv_lfsr8
  import ysyx_23060077_riscv_axil_sram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LFSR_WIDTH-1:0] seed,
  output logic [LFSR_WIDTH-1:0] state
);

  // Reload the seed in reset, otherwise step once every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed;
    end else begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/ysyx_23060077_riscv_axil_sram.sv
// AXI4-Lite data memory terminating the LSU master port. Independent read and
// write channels, one outstanding transaction each, with per-transaction
// response delay drawn from a shared LFSR (or a fixed delay).
module ysyx_23060077_riscv_axil_sram
  import ysyx_23060077_riscv_axil_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 14,
  parameter int          RAND_DELAY = 1,
  parameter int          FIX_DELAY  = 0,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [2:0] FIX_D = 3'(FIX_DELAY);

  logic [31:0] mem [DEPTH];

  logic [LFSR_WIDTH-1:0] lfsr;
  logic                  unused_lfsr_hi;
  logic [2:0]            rd_delay;
  logic [2:0]            wr_delay;

  // Word index inside the window; the byte offset bits are dropped.
  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] addr);
    return DEPTH_LOG2'((addr - BASE_ADDR) >> 2);
  endfunction

  ysyx_23060077_riscv_lfsr8 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (LFSR_SEED),
    .state (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[7:6];
  assign rd_delay = (RAND_DELAY != 0) ? lfsr[2:0] : FIX_D;
  assign wr_delay = (RAND_DELAY != 0) ? lfsr[5:3] : FIX_D;

  // ---------------------------------------------------------------- read side
  rd_state_t             r_state;
  logic [31:0]           raddr_q;
  logic [31:0]           rd_addr;
  logic [31:0]           rd_word;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;
  logic [2:0]            rcnt;
  logic                  rvalid_q;
  logic                  rd_ok;

  // While idle the incoming address feeds the port so a zero delay answers next cycle.
  assign rd_addr = (r_state == R_IDLE) ? araddr : raddr_q;
  assign rd_ok   = in_window(rd_addr, BASE_ADDR, DEPTH_LOG2);
  assign rd_word = mem[word_idx(rd_addr)];

  assign arready = (r_state == R_IDLE) && !rst;
  assign rvalid  = rvalid_q && !rst;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // Read channel FSM: accept address, count down the delay, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= R_IDLE;
      raddr_q  <= '0;
      rcnt     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            raddr_q <= araddr;
            if (rd_delay == 3'd0) begin
              rdata_q  <= rd_ok ? rd_word : 32'd0;
              rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
              rvalid_q <= 1'b1;
              r_state  <= R_RESP;
            end else begin
              rcnt    <= rd_delay - 3'd1;
              r_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (rcnt == 3'd0) begin
            rdata_q  <= rd_ok ? rd_word : 32'd0;
            rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            rvalid_q <= 1'b1;
            r_state  <= R_RESP;
          end else begin
            rcnt <= rcnt - 3'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- write side
  wr_state_t             w_state;
  logic                  have_aw;
  logic                  have_w;
  logic [31:0]           awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [2:0]            wcnt;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  aw_take;
  logic                  w_take;
  logic                  both_held;
  logic                  wr_ok;
  logic                  commit;

  // A captured beat wins over the live bus so either arrival order works.
  assign wr_addr   = have_aw ? awaddr_q : awaddr;
  assign wr_data   = have_w  ? wdata_q  : wdata;
  assign wr_strb   = have_w  ? wstrb_q  : wstrb;
  assign wr_idx    = word_idx(wr_addr);
  assign wr_ok     = in_window(wr_addr, BASE_ADDR, DEPTH_LOG2);
  assign aw_take   = (w_state == W_IDLE) && !have_aw && awvalid;
  assign w_take    = (w_state == W_IDLE) && !have_w && wvalid;
  assign both_held = (w_state == W_IDLE) && (have_aw || awvalid) && (have_w || wvalid);
  assign commit    = !rst && wr_ok &&
                     ((both_held && wr_delay == 3'd0) ||
                      (w_state == W_WAIT && wcnt == 3'd0));

  assign awready = (w_state == W_IDLE) && !have_aw && !rst;
  assign wready  = (w_state == W_IDLE) && !have_w && !rst;
  assign bvalid  = bvalid_q && !rst;
  assign bresp   = bresp_q;

  // Write channel FSM: gather AW and W in any order, delay, then respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state  <= W_IDLE;
      have_aw  <= 1'b0;
      have_w   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wcnt     <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (both_held) begin
            awaddr_q <= wr_addr;
            wdata_q  <= wr_data;
            wstrb_q  <= wr_strb;
            have_aw  <= 1'b1;
            have_w   <= 1'b1;
            if (wr_delay == 3'd0) begin
              bvalid_q <= 1'b1;
              bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
              w_state  <= W_RESP;
            end else begin
              wcnt    <= wr_delay - 3'd1;
              w_state <= W_WAIT;
            end
          end else begin
            if (aw_take) begin
              awaddr_q <= awaddr;
              have_aw  <= 1'b1;
            end
            if (w_take) begin
              wdata_q <= wdata;
              wstrb_q <= wstrb;
              have_w  <= 1'b1;
            end
          end
        end
        W_WAIT: begin
          if (wcnt == 3'd0) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            w_state  <= W_RESP;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q <= 1'b0;
            have_aw  <= 1'b0;
            have_w   <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-masked memory write; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule
